// File: rtl/vfr_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// vfr_prefetch_pkg : shared types and width helpers for the burst prefetcher
// Rev 1.0
// ============================================================================
package vfr_prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        FINISH = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int burst_cnt_width(input int max_burst);
        return clog2(max_burst) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vfr_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// vfr_prefetch_fifo : show-ahead FIFO on a synchronous-read RAM with bypass
// Rev 1.0
// ============================================================================
module vfr_prefetch_fifo
    import vfr_prefetch_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       data,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  used
);
    localparam int PTR_WIDTH = clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr, rd_addr_next;
    logic [WIDTH-1:0]     ram_q, bypass_q;
    logic                 use_bypass, pop_ok;

    assign empty        = (used == '0);
    assign pop_ok       = pop & ~empty;
    assign rd_addr_next = flush ? '0 : rd_ptr + PTR_WIDTH'(pop_ok);
    assign data         = use_bypass ? bypass_q : ram_q;

    // RAM reads the head for next cycle; a same-cycle write to that slot
    // returns old data, so the written word is forwarded through bypass_q.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
        ram_q    <= mem[rd_addr_next];
        bypass_q <= push_data;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            used       <= '0;
            use_bypass <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            rd_ptr     <= rd_addr_next;
            used       <= used + CNT_WIDTH'(push) - CNT_WIDTH'(pop_ok);
            use_bypass <= push && (wr_ptr == rd_addr_next);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vfr_burst_read_prefetcher.sv
`default_nettype none
// ============================================================================
// vfr_burst_read_prefetcher : credit-limited Avalon-MM burst reader feeding a
// show-ahead prefetch FIFO.   Rev 1.0
// ============================================================================
module vfr_burst_read_prefetcher
    import vfr_prefetch_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_WIDTH  = 24
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [ADDR_WIDTH-1:0]                 start_addr,
    input  logic [LEN_WIDTH-1:0]                  start_len,
    input  logic                                  clear,
    output logic                                  busy,
    output logic [ADDR_WIDTH-1:0]                 av_address,
    output logic [burst_cnt_width(MAX_BURST)-1:0] av_burstcount,
    output logic                                  av_read,
    input  logic                                  av_waitrequest,
    input  logic [DATA_WIDTH-1:0]                 av_readdata,
    input  logic                                  av_readdatavalid,
    output logic [DATA_WIDTH-1:0]                 data_out,
    input  logic                                  read,
    output logic                                  stall_out
);
    localparam int BYTES_PER_WORD  = bytes_per_word(DATA_WIDTH);
    localparam int BURST_CNT_WIDTH = burst_cnt_width(MAX_BURST);
    localparam int WORD_SHIFT      = clog2(BYTES_PER_WORD);
    localparam int BURST_BITS      = clog2(MAX_BURST);
    localparam int CNT_WIDTH       = clog2(FIFO_DEPTH) + 1;
    localparam int SUM_WIDTH       = CNT_WIDTH + 1;

    state_t                     state, state_next;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [LEN_WIDTH-1:0]       remaining;
    logic [CNT_WIDTH-1:0]       outstanding, outstanding_next, used;
    logic                       fifo_empty, accept, beat, start_ok, issue_req, credit_ok;
    logic [BURST_BITS-1:0]      word_off;
    logic [BURST_CNT_WIDTH-1:0] to_boundary, burst_len;
    logic [SUM_WIDTH-1:0]       reserved_after;

    assign accept    = av_read & ~av_waitrequest;
    assign beat      = av_readdatavalid & (outstanding != '0);
    assign start_ok  = start & (start_len != '0);
    assign busy      = (state != IDLE);
    assign stall_out = fifo_empty;

    // Clip each burst so it never crosses a MAX_BURST-word aligned window.
    assign word_off    = addr[WORD_SHIFT +: BURST_BITS];
    assign to_boundary = BURST_CNT_WIDTH'(MAX_BURST) - BURST_CNT_WIDTH'(word_off);
    assign burst_len   = (remaining < LEN_WIDTH'(to_boundary)) ?
                         remaining[BURST_CNT_WIDTH-1:0] : to_boundary;

    assign reserved_after = SUM_WIDTH'(used) + SUM_WIDTH'(outstanding) + SUM_WIDTH'(burst_len);
    assign credit_ok      = (reserved_after <= SUM_WIDTH'(FIFO_DEPTH));
    assign outstanding_next = outstanding
                            + (accept ? CNT_WIDTH'(av_burstcount) : CNT_WIDTH'(0))
                            - (beat   ? CNT_WIDTH'(1)             : CNT_WIDTH'(0));

    assign issue_req = (state == ISSUE) & ~clear & ~av_read & (remaining != '0) & credit_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = ISSUE;
            ISSUE:   if (accept && (remaining == LEN_WIDTH'(av_burstcount))) state_next = FINISH;
            FINISH:  if ((outstanding == '0) && fifo_empty) state_next = IDLE;
            DRAIN:   if ((outstanding_next == '0) && !(av_read && av_waitrequest)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A request stalled by waitrequest must still complete, so it keeps us in DRAIN.
        if (clear) begin
            if (state == IDLE) begin
                state_next = IDLE;
            end else if ((av_read && av_waitrequest) || (outstanding_next != '0)) begin
                state_next = DRAIN;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr          <= '0;
            remaining     <= '0;
            outstanding   <= '0;
            av_read       <= 1'b0;
            av_address    <= '0;
            av_burstcount <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (accept) begin
                av_read <= 1'b0;
            end
            if (issue_req) begin
                av_read       <= 1'b1;
                av_address    <= addr;
                av_burstcount <= burst_len;
            end
            if (clear) begin
                remaining <= '0;
            end else if ((state == IDLE) && start_ok) begin
                addr      <= start_addr;
                remaining <= start_len;
            end else if ((state == ISSUE) && accept) begin
                addr      <= addr + (ADDR_WIDTH'(av_burstcount) << WORD_SHIFT);
                remaining <= remaining - LEN_WIDTH'(av_burstcount);
            end
        end
    end

    vfr_prefetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (av_readdatavalid && (state != DRAIN)),
        .push_data (av_readdata),
        .pop       (read),
        .flush     (clear),
        .data      (data_out),
        .empty     (fifo_empty),
        .used      (used)
    );

endmodule
`default_nettype wire

// File: doc/vfr_burst_read_prefetcher.md
Name: vfr_burst_read_prefetcher

Overview:
- Avalon-MM burst read master with an on-chip prefetch FIFO.
- Fetches a contiguous run of DATA_WIDTH-bit words from external memory.
- Presents them on a pull-style interface to the downstream width unpacker: data, read, stall.
- Sits directly upstream of the unpacker in the frame-reader read path and keeps it fed across memory latency.

Parameters:
- DATA_WIDTH, 128, memory word width in bits; a multiple of 8.
- ADDR_WIDTH, 32, Avalon byte address width.
- MAX_BURST, 32, maximum burst length in words; a power of 2.
- FIFO_DEPTH, 64, prefetch FIFO depth in words; a power of 2 and >= 2*MAX_BURST.
- LEN_WIDTH, 24, width of the transfer length in words.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a transfer; ignored while busy=1.
- start_addr  in  ADDR_WIDTH  byte address of the first word; word aligned.
- start_len  in  LEN_WIDTH  number of words to fetch; 0 means no-op.
- clear  in  1  abort: stop issuing, flush the FIFO, discard in-flight data.
- busy  out  1  high from an accepted start until all words are delivered or the abort completes.
- av_address  out  ADDR_WIDTH  burst start byte address.
- av_burstcount  out  log2(MAX_BURST)+1  burst length in words.
- av_read  out  1  read request.
- av_waitrequest  in  1  slave stall.
- av_readdata  in  DATA_WIDTH  returned data.
- av_readdatavalid  in  1  returned-data strobe.
- data_out  out  DATA_WIDTH  FIFO head word; valid when stall_out=0.
- read  in  1  consumer pop; may be asserted combinationally.
- stall_out  out  1  FIFO empty.

Behaviour:
- Reset values:
  - busy=0, av_read=0, av_address=0, av_burstcount=0, stall_out=1.
  - FIFO empty; all counters and the state register cleared.
  - data_out content don't-care.
- Pop: a word is popped in any cycle with read=1 and stall_out=0.
  - read while stall_out=1 has no effect.
  - data_out shows the FIFO head with zero-cycle latency (show-ahead).
  - The next word appears the cycle after a pop.
- Push: every av_readdatavalid=1 writes av_readdata into the FIFO, except in DRAIN, where it is discarded.
- A word pushed in cycle N is poppable in cycle N+1.
- Simultaneous push and pop leave occupancy unchanged.
- Credit: reserved = occupancy + outstanding, where outstanding is words requested but not yet returned.
  - A burst of length L is issued only if reserved + L <= FIFO_DEPTH.
  - The FIFO can therefore never overflow.
- States:
  - IDLE:
    - start with start_len != 0 latches addr and remaining=start_len, sets busy=1, goes to ISSUE.
    - start with start_len == 0 does nothing; busy stays 0.
  - ISSUE:
    - L = min(MAX_BURST, remaining), further clipped so the burst does not cross a MAX_BURST*DATA_WIDTH/8-byte boundary.
    - If credit allows: assert av_read with av_address=addr and av_burstcount=L.
    - Hold all three stable while av_waitrequest=1.
    - On acceptance (av_read & ~av_waitrequest): addr += L*DATA_WIDTH/8, remaining -= L, outstanding += L.
    - If remaining reaches 0, go to FINISH; otherwise stay in ISSUE.
    - If credit is insufficient, av_read=0 and the block stays in ISSUE. No separate wait state is needed.
  - FINISH: when outstanding=0 and the FIFO is empty, busy falls and the state goes to IDLE.
- clear (any state, highest priority after reset):
  - The FIFO is flushed in the same cycle; stall_out=1 next cycle.
  - remaining is set to 0.
  - If an av_read is pending with av_waitrequest=1, it is held until accepted and counted as outstanding (Avalon rule). Only then is it dropped.
  - If outstanding > 0, go to DRAIN; otherwise go to IDLE with busy=0 next cycle.
- DRAIN: discard returned beats and decrement outstanding; at 0 go to IDLE with busy=0. start is ignored in DRAIN.
- Counter widths:
  - outstanding and occupancy: log2(FIFO_DEPTH)+1 bits.
  - remaining: LEN_WIDTH bits.
  - addr wraps modulo 2^ADDR_WIDTH with no error flag.
- A start in the same cycle as clear is ignored.

Decomposition:
- Shared package vfr_prefetch_pkg holds:
  - the state enum (IDLE, ISSUE, FINISH, DRAIN);
  - the BYTES_PER_WORD and BURST_CNT_WIDTH derivations;
  - the clog2 function.
- Sub-module vfr_prefetch_fifo: synchronous show-ahead FIFO.
  - Signals: push, pop, flush, data, empty, used count.
  - Inferred RAM with a bypass register for the write-then-read-next-cycle case.

Test Plan:
- Aligned transfer: start addr=0x1000, len=70, no backpressure, slave latency 5.
  - Bursts of 32, 32, 6 at 0x1000, 0x1200, 0x1400.
  - 70 words popped in order; busy drops after the last pop.
- Credit stall: len=200, consumer never reads.
  - Exactly 64 words requested, then av_read stays 0.
  - After 32 pops, one more 32-beat burst is issued.
- Waitrequest: av_waitrequest=1 for 4 cycles on the first burst.
  - av_address and av_burstcount stable throughout; single acceptance counted.
- Boundary split: addr=0x11F0, len=4 with MAX_BURST=32 and 16-byte words.
  - Burst 1 at 0x11F0 (1 beat); burst 2 at 0x1200 (3 beats).
- Abort with 20 words in flight and 10 in the FIFO:
  - stall_out=1 next cycle.
  - 20 returned beats discarded; busy falls the cycle after the 20th beat.
  - A new start then fetches fresh data correctly.
- Reset mid-transfer: reset asserted during a burst.
  - All outputs return to reset values on the next edge.
  - Stale readdatavalid beats after reset are ignored by the bench; the slave model is reset too.
